// File: rtl/sha256_spi_master.sv
// rtl/sha256_spi_master.sv - SPI register-access master (16-bit frames, SCK idle high)
// A write is one frame; a read is an address frame followed by a data frame.
module sha256_spi_master #(
    parameter int CLK_DIV = 5,
    parameter int LEAD    = 2,
    parameter int GAP     = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rw,
    input  logic [6:0] i_cmd_addr,
    input  logic [7:0] i_cmd_wdata,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_busy,
    output logic       o_spi_sck,
    output logic       o_spi_ss_n,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);

    localparam logic [7:0] CD_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] LEAD_M1 = 8'(LEAD - 1);
    localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  hp_q, hp_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        rd_q, rd_d;
    logic        second_q, second_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        ss_n_q, ss_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    // Only the low byte of the receive register carries read data.
    logic unused_rx;
    assign unused_rx = rx_q[15];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hp_d       = hp_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_d       = rd_q;
        second_d   = second_q;
        ss_n_d     = ss_n_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid && ready_q) begin
                    state_d  = S_LEAD;
                    cnt_d    = 8'd0;
                    ss_n_d   = 1'b0;
                    tx_d     = i_cmd_rw ? {1'b1, i_cmd_addr, i_cmd_wdata}
                                        : {1'b0, i_cmd_addr, 8'h00};
                    rd_d     = ~i_cmd_rw;
                    second_d = 1'b0;
                end
            end
            S_LEAD: begin
                if (cnt_q == LEAD_M1) begin
                    // First half-period opens with the falling edge carrying bit 15.
                    state_d = S_SHIFT;
                    cnt_d   = 8'd0;
                    hp_d    = 5'd0;
                    sck_d   = 1'b0;
                    mosi_d  = tx_q[15];
                    tx_d    = {tx_q[14:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CD_M1) begin
                    cnt_d = 8'd0;
                    if (hp_q == 5'd31) begin
                        state_d = S_TRAIL;
                        if (second_q) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = rx_q[7:0];
                        end
                    end else begin
                        hp_d  = hp_q + 5'd1;
                        sck_d = ~sck_q;
                        if (sck_q) begin
                            mosi_d = tx_q[15];
                            tx_d   = {tx_q[14:0], 1'b0};
                        end else begin
                            rx_d = {rx_q[14:0], i_spi_miso};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_TRAIL: begin
                if (cnt_q == LEAD_M1) begin
                    state_d = S_GAP;
                    cnt_d   = 8'd0;
                    ss_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_M1) begin
                    cnt_d = 8'd0;
                    if (rd_q && !second_q) begin
                        state_d  = S_LEAD;
                        second_d = 1'b1;
                        tx_d     = 16'h0000;
                        ss_n_d   = 1'b0;
                    end else begin
                        state_d  = S_IDLE;
                        rd_d     = 1'b0;
                        second_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ss_n_d  = 1'b1;
                sck_d   = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            hp_q       <= 5'd0;
            tx_q       <= 16'h0000;
            rx_q       <= 16'h0000;
            rd_q       <= 1'b0;
            second_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            sck_q      <= 1'b1;
            mosi_q     <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hp_q       <= hp_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_q       <= rd_d;
            second_q   <= second_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            ss_n_q     <= ss_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_busy      = busy_q;
    assign o_spi_ss_n  = ss_n_q;
    assign o_spi_sck   = sck_q;
    assign o_spi_mosi  = mosi_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;

endmodule

// File: doc/sha256_spi_master.md
SHA256_SPI_MASTER -- requirements
Module: sha256_spi_master

Interface
Parameters:
REQ-001 SHALL have parameter CLK_DIV, default 5: SCK half-period in i_clk cycles, legal range 1..255.
REQ-002 SHALL have parameter LEAD, default 2: cycles from SS_n low to the first SCK edge, and from the last SCK edge to SS_n high, legal range 1..15.
REQ-003 SHALL have parameter GAP, default 10: cycles SS_n is held high between frames and after a command, legal range 1..255.

Ports:
REQ-004 SHALL have i_clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have i_cmd_valid  input  1  command request.
REQ-007 SHALL have o_cmd_ready  output  1  block idle; a command is accepted when i_cmd_valid and o_cmd_ready are both high.
REQ-008 SHALL have i_cmd_rw  input  1  1=write, 0=read; driven as frame bit 15.
REQ-009 SHALL have i_cmd_addr  input  7  register address; frame bits 14:8.
REQ-010 SHALL have i_cmd_wdata  input  8  write data; frame bits 7:0, ignored for reads.
REQ-011 SHALL have o_rd_data  output  8  last read result, held until the next read completes.
REQ-012 SHALL have o_rd_valid  output  1  one-cycle pulse when o_rd_data updates.
REQ-013 SHALL have o_busy  output  1  high from acceptance until return to IDLE.
REQ-014 SHALL have o_spi_sck, o_spi_ss_n, o_spi_mosi  outputs  1 each  SPI master lines.
REQ-015 SHALL have i_spi_miso  input  1  SPI slave data.

Function
REQ-016 SPI mode: SCK idles high; MOSI changes on SCK falling edges; slave samples on rising edges; MSB first; frame = 16 bits {rw, addr[6:0], data[7:0]}.
REQ-017 FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE->LEAD on acceptance.
- LEAD->SHIFT after LEAD cycles.
- SHIFT->TRAIL after 32 SCK half-periods.
- TRAIL->GAP after LEAD cycles.
- GAP->IDLE, or GAP->LEAD for a pending read data frame.
REQ-018 o_cmd_ready SHALL be high only in IDLE; o_busy = !o_cmd_ready; commands arriving while busy are neither accepted nor queued.
REQ-019 On acceptance, rw/addr/wdata SHALL be latched into a 16-bit shift register; o_spi_ss_n goes low the following cycle and stays low through LEAD, SHIFT and TRAIL.
REQ-020 In SHIFT, o_spi_sck SHALL toggle every CLK_DIV cycles, starting with a falling edge, giving exactly 16 falling and 16 rising edges.
- SCK ends high.
- MOSI is updated to the next bit in the cycle of each falling edge (bit 15 on the first).
REQ-021 i_spi_miso SHALL be sampled in the i_clk cycle in which o_spi_sck goes high, and shifted into a 16-bit receive register (LSB in).
REQ-022 A write command SHALL be one frame; total busy time = 1 + LEAD + 32*CLK_DIV + LEAD + GAP cycles.
REQ-023 A read command SHALL be two frames separated by GAP.
- Frame 1 = {0, addr, 8'h00}.
- Frame 2 = 16'h0000 on MOSI, with MISO captured.
- o_rd_data = receive register bits 7:0 after frame 2.
- o_rd_valid pulses in the first TRAIL cycle of frame 2.
REQ-024 Outside SS_n-low periods, o_spi_mosi SHALL be 0 and o_spi_sck SHALL be 1.
REQ-025 Half-period, LEAD, GAP and bit counters SHALL be sized for the maximum legal parameters and SHALL not wrap within a frame.

Reset
REQ-026 While i_rst is high at a clock edge, outputs SHALL take these values on that edge:
- state = IDLE, o_spi_ss_n = 1, o_spi_sck = 1, o_spi_mosi = 0.
- o_rd_data = 8'h00, o_rd_valid = 0, o_busy = 0, o_cmd_ready = 0.
REQ-027 o_cmd_ready SHALL rise on the first clock edge after i_rst falls.
REQ-028 Reset asserted mid-frame SHALL abort the transaction:
- no o_rd_valid pulse;
- SS_n high within one cycle;
- no partial state retained.

Verification
REQ-029 Write rw=1, addr=7'h40, wdata=8'h01, defaults -> MOSI bits on successive falling edges = 16'hC001; SS_n low for 2+160+2 cycles; ready returns after 175 cycles total.
REQ-030 Read addr=7'h05, with slave model returning 8'hA5 in frame-2 bits 7:0 -> frame 1 = 16'h0500, frame 2 MOSI all 0, o_rd_data=8'hA5, single o_rd_valid pulse.
REQ-031 i_cmd_valid held high for two writes -> second accepted only after GAP; SS_n high for exactly 10 cycles plus 1 between frames.
REQ-032 CLK_DIV=1, LEAD=1, GAP=1, write 16'hFFFF -> SCK toggles every cycle, 32 edges, MOSI high for all 16 bits.
REQ-033 i_rst asserted during bit 7 of a read -> SS_n=1, SCK=1, MOSI=0 after that edge; no o_rd_valid; next command runs normally.
REQ-034 i_cmd_valid pulsed while busy -> ignored; exactly one frame sequence observed.
